spi_fsm: RTL and testbench

SPI_FSM -- requirements
Module: spi_fsm

---
 rtl/spi_pkg.sv | 19 +
 rtl/bit_counter.sv | 28 ++
 rtl/spi_fsm.sv | 98 +++++++++
 tb/tb_spi_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave control FSM: state encoding and
// default header/data lengths.
package spi_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    LATCH_ADDR  = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } spi_state_e;

endpackage

// File: rtl/bit_counter.sv
// Saturating SCLK edge counter; clr wins over inc, and the count holds at N
// so it can never wrap inside a transaction.
module bit_counter #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic         C,
  input  logic         R,
  input  logic         clr,
  input  logic         inc,
  output logic         done,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LIMIT = W'(N);

  assign done = (count == LIMIT);

  always_ff @(posedge C or posedge R) begin
    if (R)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !done)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: counts the header, branches on R/W and
// produces one-state Moore enables for the address latch, shift load,
// memory write and MISO driver.
module spi_fsm
  import spi_pkg::*;
#(
  parameter  int ADDR_BITS = ADDR_BITS_DEF,
  parameter  int DATA_BITS = DATA_BITS_DEF,
  localparam int CNT_MAX   = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS,
  localparam int CW        = $clog2(CNT_MAX + 1)
) (
  input  logic          C,
  input  logic          R,
  input  logic          cs,
  input  logic          sclk_pos,
  input  logic          sclk_neg,
  input  logic          rw,
  output logic          addr_we,
  output logic          sr_we,
  output logic          dm_we,
  output logic          miso_buff,
  output spi_state_e    state_dbg,
  output logic [CW-1:0] cnt_dbg,
  output logic          cnt_full
);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

  spi_state_e    state, state_nxt;
  logic          clr, inc;
  logic [CW-1:0] count;
  logic          cnt_done;

  bit_counter #(.N(CNT_MAX), .W(CW)) u_cnt (
    .C     (C),
    .R     (R),
    .clr   (clr),
    .inc   (inc),
    .done  (cnt_done),
    .count (count)
  );

  always_ff @(posedge C or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  // The transition fires on the cycle of the last pulse itself, so the
  // compare is against N-1 (the count before this pulse is added).
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    inc       = 1'b0;
    unique case (state)
      IDLE:        clr = 1'b1;
      GET_ADDR:    inc = sclk_pos;
      LATCH_ADDR:  clr = 1'b1;
      READ_SHIFT:  inc = sclk_neg;
      WRITE_SHIFT: inc = sclk_pos;
      default:     ;
    endcase
    if (state != IDLE && cs) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:        if (!cs) state_nxt = GET_ADDR;
        GET_ADDR:    if (sclk_pos && count == ADDR_LAST) state_nxt = LATCH_ADDR;
        LATCH_ADDR:  state_nxt = rw ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD:   state_nxt = READ_SHIFT;
        READ_SHIFT:  if (sclk_neg && count == DATA_LAST) state_nxt = DONE;
        WRITE_SHIFT: if (sclk_pos && count == DATA_LAST) state_nxt = WRITE_STORE;
        WRITE_STORE: state_nxt = DONE;
        DONE:        state_nxt = DONE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_we   = 1'b0;
    sr_we     = 1'b0;
    dm_we     = 1'b0;
    miso_buff = 1'b0;
    unique case (state)
      LATCH_ADDR:  addr_we   = 1'b1;
      READ_LOAD:   sr_we     = 1'b1;
      WRITE_STORE: dm_we     = 1'b1;
      READ_SHIFT:  miso_buff = 1'b1;
      default:     ;
    endcase
  end

  assign state_dbg = state;
  assign cnt_dbg   = count;
  assign cnt_full  = cnt_done;

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: read, write, abort, async reset, spurious
// edges and back-to-back transactions with hand-derived expectations.
module tb_spi_fsm;
  import spi_pkg::*;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       cs = 1'b1;
  logic       sclk_pos = 1'b0;
  logic       sclk_neg = 1'b0;
  logic       rw = 1'b0;
  logic       addr_we, sr_we, dm_we, miso_buff;
  spi_state_e state_dbg;
  logic [3:0] cnt_dbg;
  logic       cnt_full;

  int n_checks = 0;
  int n_fail   = 0;
  int dm_pulses = 0;

  spi_fsm dut (
    .C         (C),
    .R         (R),
    .cs        (cs),
    .sclk_pos  (sclk_pos),
    .sclk_neg  (sclk_neg),
    .rw        (rw),
    .addr_we   (addr_we),
    .sr_we     (sr_we),
    .dm_we     (dm_we),
    .miso_buff (miso_buff),
    .state_dbg (state_dbg),
    .cnt_dbg   (cnt_dbg),
    .cnt_full  (cnt_full)
  );

  // clock / reset
  always #5 C = ~C;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // enables packed as {addr_we, sr_we, dm_we, miso_buff}
  task automatic check_out(input string tag, input spi_state_e st, input logic [3:0] en);
    check({tag, " state"}, 32'(state_dbg), 32'(st));
    check({tag, " en"}, {28'd0, addr_we, sr_we, dm_we, miso_buff}, {28'd0, en});
  endtask

  // driver tasks
  task automatic tick();
    @(posedge C);
    #1;
    if (dm_we) dm_pulses++;
  endtask

  task automatic pulse(input logic p, input logic n);
    sclk_pos = p;
    sclk_neg = n;
    tick();
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
  endtask

  task automatic start_txn();
    cs = 1'b0;
    tick();
    check_out("start", GET_ADDR, 4'b0000);
    check("start cnt", {28'd0, cnt_dbg}, 32'd0);
  endtask

  task automatic send_header(input logic [7:0] hdr, input bit spurious);
    for (int i = 0; i < 8; i++) begin
      if (spurious) pulse(1'b0, 1'b1);
      if (i == 7) rw = hdr[0];
      pulse(1'b1, spurious && (i % 2 == 1));
      if (i < 7) begin
        check("hdr state", 32'(state_dbg), 32'(GET_ADDR));
        if (spurious) check("hdr cnt", {28'd0, cnt_dbg}, i + 1);
        tick();
      end else begin
        check_out("latch", LATCH_ADDR, 4'b1000);
      end
    end
  endtask

  task automatic read_data(input bit spurious);
    tick();
    check_out("rd load", READ_LOAD, 4'b0100);
    tick();
    check_out("rd shift", READ_SHIFT, 4'b0001);
    check("rd cnt", {28'd0, cnt_dbg}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (spurious) begin
        pulse(1'b1, 1'b0);
        check("rd spur cnt", {28'd0, cnt_dbg}, i);
      end
      pulse(1'b0, 1'b1);
      if (i < 7) begin
        check_out("rd bit", READ_SHIFT, 4'b0001);
        tick();
      end else begin
        check_out("rd done", DONE, 4'b0000);
      end
    end
  endtask

  task automatic write_data();
    tick();
    check_out("wr shift", WRITE_SHIFT, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 1'b0);
      if (i < 7) begin
        check_out("wr bit", WRITE_SHIFT, 4'b0000);
        tick();
      end else begin
        check_out("wr store", WRITE_STORE, 4'b0010);
      end
    end
    tick();
    check_out("wr done", DONE, 4'b0000);
  endtask

  task automatic finish_txn();
    cs = 1'b1;
    tick();
    check_out("end", IDLE, 4'b0000);
  endtask

  initial begin
    #1;
    check_out("reset", IDLE, 4'b0000);
    check("reset cnt", {28'd0, cnt_dbg}, 32'd0);
    tick();
    R = 1'b0;
    tick();
    check_out("idle cs high", IDLE, 4'b0000);

    // read, header 0x55
    start_txn();
    send_header(8'h55, 1'b0);
    read_data(1'b0);
    tick();
    check_out("done hold", DONE, 4'b0000);
    finish_txn();

    // write, header 0x54
    dm_pulses = 0;
    start_txn();
    send_header(8'h54, 1'b0);
    write_data();
    finish_txn();
    check("wr dm pulses", dm_pulses, 32'd1);

    // abort coincident with the final data sclk_pos
    dm_pulses = 0;
    start_txn();
    send_header(8'h54, 1'b0);
    tick();
    check_out("ab shift", WRITE_SHIFT, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0);
      tick();
    end
    cs = 1'b1;
    pulse(1'b1, 1'b0);
    check_out("abort", IDLE, 4'b0000);
    tick();
    check_out("abort hold", IDLE, 4'b0000);
    check("ab dm pulses", dm_pulses, 32'd0);

    // async reset between edges in READ_SHIFT
    dm_pulses = 0;
    start_txn();
    send_header(8'h55, 1'b0);
    tick();
    tick();
    check_out("ar shift", READ_SHIFT, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1);
      tick();
    end
    #2 R = 1'b1;
    #1;
    check_out("async rst", IDLE, 4'b0000);
    check("async rst cnt", {28'd0, cnt_dbg}, 32'd0);
    cs = 1'b1;
    #1 R = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("post rst", IDLE, 4'b0000);
    end
    check("ar dm pulses", dm_pulses, 32'd0);

    // spurious edges in GET_ADDR and READ_SHIFT
    start_txn();
    send_header(8'h55, 1'b1);
    read_data(1'b1);
    finish_txn();

    // back-to-back: cs high then low in consecutive cycles
    start_txn();
    send_header(8'h55, 1'b0);
    read_data(1'b0);
    cs = 1'b1;
    tick();
    check_out("b2b gap", IDLE, 4'b0000);
    dm_pulses = 0;
    start_txn();
    send_header(8'h54, 1'b0);
    write_data();
    finish_txn();
    check("b2b dm pulses", dm_pulses, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
